// File: rtl/mc_key_parser.sv
// -----------------------------------------------------------------------------
// mc_key_parser
//
// Memcache ASCII front end for the lookup3 hash pipeline. Parses
// "get <key>[ <key>...]\r\n" from the receive byte stream and emits each key
// packed big-endian into three 32-bit words together with its byte length.
// Malformed commands and over-long keys raise cmd_err, and the rest of the
// line is discarded up to the next '\n'.
//
// Build option:
//   MC_KEY_MULTI_EN  defined   : a space terminates a key (multi-key get).
//                    undefined : only '\r' terminates a key; a space after
//                                key bytes is a protocol error.
//
// Parameters:
//   MAX_KEY     maximum accepted key bytes, 1..12.
//
// Ports:
//   CLK         clock
//   RST         synchronous, active-high reset
//   in_data     request byte
//   in_valid    in_data valid this cycle (no backpressure)
//   k0,k1,k2    key bytes 0..3 / 4..7 / 8..11, first byte in [31:24]
//   key_length  key byte count of the last emitted key
//   key_valid   one-cycle pulse: k0..k2 / key_length hold a new key
//   cmd_err     one-cycle pulse: protocol error, command discarded
// -----------------------------------------------------------------------------
module mc_key_parser #(
  parameter int unsigned MAX_KEY = 12
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [31:0] k0,
  output logic [31:0] k1,
  output logic [31:0] k2,
  output logic [7:0]  key_length,
  output logic        key_valid,
  output logic        cmd_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_G    = 3'd1;
  localparam logic [2:0] S_E    = 3'd2;
  localparam logic [2:0] S_T    = 3'd3;
  localparam logic [2:0] S_KEY  = 3'd4;
  localparam logic [2:0] S_LF   = 3'd5;
  localparam logic [2:0] S_DROP = 3'd6;

  localparam logic [7:0] CH_G  = 8'h67;
  localparam logic [7:0] CH_E  = 8'h65;
  localparam logic [7:0] CH_T  = 8'h74;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [3:0] MAX_CNT = 4'(MAX_KEY);

  logic [2:0]        state, state_nx;
  logic [0:11][7:0]  key_buf;   // index 0 is the first key byte
  logic [3:0]        count;
  logic              got_key;   // at least one key emitted in this command

  logic is_key_byte;
  logic do_store, do_emit, do_err;
  logic clr_buf, clr_got, set_got;

  assign is_key_byte = (in_data >= 8'h21) && (in_data <= 8'h7E);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    do_store = 1'b0;
    do_emit  = 1'b0;
    do_err   = 1'b0;
    clr_buf  = 1'b0;
    clr_got  = 1'b0;
    set_got  = 1'b0;
    if (in_valid) begin
      case (state)
        S_IDLE: begin
          if (in_data == CH_G) state_nx = S_G;
          else if (in_data != CH_CR && in_data != CH_LF) begin
            do_err   = 1'b1;
            state_nx = S_DROP;
          end
        end
        S_G: begin
          if (in_data == CH_E) state_nx = S_E;
          else begin do_err = 1'b1; state_nx = S_DROP; end
        end
        S_E: begin
          if (in_data == CH_T) state_nx = S_T;
          else begin do_err = 1'b1; state_nx = S_DROP; end
        end
        S_T: begin
          if (in_data == CH_SP) begin
            clr_buf  = 1'b1;
            clr_got  = 1'b1;
            state_nx = S_KEY;
          end else begin
            do_err   = 1'b1;
            state_nx = S_DROP;
          end
        end
        S_KEY: begin
          if (is_key_byte) begin
            if (count < MAX_CNT) do_store = 1'b1;
            else begin do_err = 1'b1; state_nx = S_DROP; end
          end else if (in_data == CH_SP) begin
            // Repeated spaces (count == 0) are ignored in both builds.
`ifdef MC_KEY_MULTI_EN
            if (count != 4'd0) begin
              do_emit = 1'b1;
              clr_buf = 1'b1;
              set_got = 1'b1;
            end
`else
            if (count != 4'd0) begin
              do_err   = 1'b1;
              state_nx = S_DROP;
            end
`endif
          end else if (in_data == CH_CR) begin
            if (count != 4'd0) begin
              do_emit  = 1'b1;
              state_nx = S_LF;
            end else if (got_key) begin
              state_nx = S_LF;
            end else begin
              do_err   = 1'b1;
              state_nx = S_DROP;
            end
          end else begin
            // Control bytes, 0x7F, 0x80..0xFF and a bare '\n' all land here;
            // a bare '\n' therefore waits in DROP for the following '\n'.
            do_err   = 1'b1;
            state_nx = S_DROP;
          end
        end
        S_LF: begin
          if (in_data == CH_LF) state_nx = S_IDLE;
          else begin do_err = 1'b1; state_nx = S_DROP; end
        end
        S_DROP: begin
          if (in_data == CH_LF) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, e.g. an emit reads the buffer before the
  // same-cycle clear takes effect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      // NOTE: the key buffer is reset, not left undefined, because bytes
      // beyond the key length must read as zero in k0..k2.
      key_buf    <= '0;
      count      <= '0;
      got_key    <= 1'b0;
      k0         <= '0;
      k1         <= '0;
      k2         <= '0;
      key_length <= '0;
      key_valid  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state     <= state_nx;
      key_valid <= do_emit;
      cmd_err   <= do_err;

      if (do_emit) begin
        k0         <= {key_buf[0], key_buf[1], key_buf[2],  key_buf[3]};
        k1         <= {key_buf[4], key_buf[5], key_buf[6],  key_buf[7]};
        k2         <= {key_buf[8], key_buf[9], key_buf[10], key_buf[11]};
        key_length <= {4'd0, count};
      end

      if (clr_buf) begin
        key_buf <= '0;
        count   <= '0;
      end else if (do_store) begin
        key_buf[count] <= in_data;
        count          <= count + 4'd1;
      end

      if (clr_got)      got_key <= 1'b0;
      else if (set_got) got_key <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_key_parser.sv
// -----------------------------------------------------------------------------
// tb_mc_key_parser
//
// Self-checking bench for mc_key_parser. Each byte segment is parsed by a
// string-level reference model that records, per byte index, whether that
// byte yields an emitted key (and its packed words) or a protocol error. The
// bench then drives the bytes (optionally with idle gaps) and checks all
// outputs on every cycle. Honors MC_KEY_MULTI_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mc_key_parser;

  localparam int MAX_KEY = 12;
  localparam byte unsigned SP = 8'h20;
  localparam byte unsigned CR = 8'h0D;
  localparam byte unsigned LF = 8'h0A;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic [31:0] k0, k1, k2;
  logic [7:0]  key_length;
  logic        key_valid, cmd_err;

  mc_key_parser #(.MAX_KEY(MAX_KEY)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .k0         (k0),
    .k1         (k1),
    .k2         (k2),
    .key_length (key_length),
    .key_valid  (key_valid),
    .cmd_err    (cmd_err)
  );

  always #5 CLK = ~CLK;

  int vectors    = 0;
  int miscompares = 0;

  byte unsigned seg[$];
  int           exp_kind[$];   // 0 nothing, 1 key emitted, 2 protocol error
  logic [31:0]  exp_w0[$], exp_w1[$], exp_w2[$];
  logic [7:0]   exp_len[$];
  logic [31:0]  cur_k0, cur_k1, cur_k2;
  logic [7:0]   cur_len;
  byte unsigned get_str[4] = '{8'h67, 8'h65, 8'h74, 8'h20};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus construction ----------------
  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) seg.push_back(s[i]);
  endtask

  task automatic add_line(input string s);
    add_str(s);
    seg.push_back(CR);
    seg.push_back(LF);
  endtask

  task automatic add_key(input int n);
    repeat (n) seg.push_back(8'($urandom_range(33, 126)));
  endtask

  // ---------------- reference model ----------------
  function automatic int drop_from(input int p);
    for (int q = p + 1; q < seg.size(); q++)
      if (seg[q] == LF) return q + 1;
    return seg.size();
  endfunction

  function automatic void mark_err(input int p);
    if (p < exp_kind.size()) exp_kind[p] = 2;
  endfunction

  function automatic void emit_key(input int p, input byte unsigned key[$]);
    logic [31:0] w[3] = '{default: 32'h0};
    for (int i = 0; i < key.size(); i++)
      w[i/4] = w[i/4] | (32'(key[i]) << (24 - 8 * (i % 4)));
    exp_kind[p] = 1;
    exp_w0[p]   = w[0];
    exp_w1[p]   = w[1];
    exp_w2[p]   = w[2];
    exp_len[p]  = 8'(key.size());
  endfunction

  function automatic void build_model();
    int n, i, k, p;
    bit got, done;
    byte unsigned c;
    byte unsigned key[$];
    n = seg.size();
    exp_kind = {}; exp_w0 = {}; exp_w1 = {}; exp_w2 = {}; exp_len = {};
    for (int j = 0; j < n; j++) begin
      exp_kind.push_back(0);
      exp_w0.push_back(32'h0); exp_w1.push_back(32'h0); exp_w2.push_back(32'h0);
      exp_len.push_back(8'h0);
    end
    i = 0;
    while (i < n) begin
      if (seg[i] == CR || seg[i] == LF) begin
        i++;                                   // blank line
      end else begin
        p = -1;
        for (int j = 0; j < 4; j++)
          if (p < 0 && (i + j >= n || seg[i+j] != get_str[j])) p = i + j;
        if (p >= 0) begin
          mark_err(p);
          i = drop_from(p);
        end else begin
          k = i + 4; key = {}; got = 1'b0; done = 1'b0;
          while (!done) begin
            if (k >= n) begin
              i = n; done = 1'b1;
            end else begin
              c = seg[k];
              if (c >= 8'h21 && c <= 8'h7E) begin
                if (key.size() < MAX_KEY) begin key.push_back(c); k++; end
                else begin mark_err(k); i = drop_from(k); done = 1'b1; end
              end else if (c == SP) begin
`ifdef MC_KEY_MULTI_EN
                if (key.size() > 0) begin emit_key(k, key); key = {}; got = 1'b1; end
                k++;
`else
                if (key.size() > 0) begin mark_err(k); i = drop_from(k); done = 1'b1; end
                else k++;
`endif
              end else if (c == CR && (key.size() > 0 || got)) begin
                if (key.size() > 0) emit_key(k, key);
                if (k + 1 < n && seg[k+1] == LF) i = k + 2;
                else begin mark_err(k + 1); i = drop_from(k + 1); end
                done = 1'b1;
              end else begin
                mark_err(k); i = drop_from(k); done = 1'b1;
              end
            end
          end
        end
      end
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic check_cycle(input int kind, input int p);
    if (kind == 1) begin
      cur_k0 = exp_w0[p]; cur_k1 = exp_w1[p]; cur_k2 = exp_w2[p]; cur_len = exp_len[p];
    end
    check($sformatf("key_valid@%0d", p), 32'(key_valid), 32'(kind == 1));
    check($sformatf("cmd_err@%0d", p),   32'(cmd_err),   32'(kind == 2));
    check($sformatf("k0@%0d", p), k0, cur_k0);
    check($sformatf("k1@%0d", p), k1, cur_k1);
    check($sformatf("k2@%0d", p), k2, cur_k2);
    check($sformatf("key_length@%0d", p), 32'(key_length), 32'(cur_len));
  endtask

  // gap_mode: 0 continuous, 1 one idle cycle before each byte, 2 random gaps
  task automatic run_seg(input int gap_mode);
    int gaps;
    build_model();
    for (int p = 0; p < seg.size(); p++) begin
      if (gap_mode == 0)      gaps = 0;
      else if (gap_mode == 1) gaps = 1;
      else                    gaps = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      repeat (gaps) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge CLK); #1;
        check_cycle(0, p);
      end
      in_valid = 1'b1;
      in_data  = seg[p];
      @(posedge CLK); #1;
      check_cycle(exp_kind[p], p);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    RST      = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    cur_k0 = '0; cur_k1 = '0; cur_k2 = '0; cur_len = '0;
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_cmd_err",   32'(cmd_err),   32'h0);
    check("rst_k0", k0, 32'h0);
    check("rst_k1", k1, 32'h0);
    check("rst_k2", k2, 32'h0);
    check("rst_key_length", 32'(key_length), 32'h0);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int nk;

    seg = {}; add_line("get abcd");
    do_reset(); run_seg(0);
    check("abcd_k0", k0, 32'h61626364);
    check("abcd_len", 32'(key_length), 32'd4);

    seg = {}; add_line("get abcdefghijkl");
    do_reset(); run_seg(0);
    check("max_k0", k0, 32'h61626364);
    check("max_k1", k1, 32'h65666768);
    check("max_k2", k2, 32'h696A6B6C);
    check("max_len", 32'(key_length), 32'd12);

    seg = {}; add_line("get abcdefghijklm"); add_line("get x");
    do_reset(); run_seg(0);
    check("long_then_x_k0", k0, 32'h78000000);
    check("long_then_x_len", 32'(key_length), 32'd1);

    seg = {}; add_line("get ab cd");
    do_reset(); run_seg(0);

    seg = {}; add_line("set x"); add_line("get q");
    do_reset(); run_seg(0);
    check("set_then_q_k0", k0, 32'h71000000);

    // Reset in the middle of a command.
    seg = {}; add_line("get zz"); add_str("get ab");
    do_reset(); run_seg(0);
    do_reset();
    seg = {}; add_line("cd"); add_line("get e");
    run_seg(0);
    check("after_rst_k0", k0, 32'h65000000);
    check("after_rst_len", 32'(key_length), 32'd1);

    seg = {}; add_line("get abcd");
    do_reset(); run_seg(1);
    check("toggle_k0", k0, 32'h61626364);

    // Corner lines: repeated spaces, empty key, bare LF, stray byte after CR.
    seg = {};
    add_line("get  a  b ");
    add_line("get ");
    add_line("");
    add_str("get a"); seg.push_back(LF); add_line("get b");
    add_str("get c"); seg.push_back(CR); add_line("x");
    add_line("get a b c");
    add_line("get abcdefghijkl abcdefghijkl");
    do_reset(); run_seg(0);

    // Random command stream with random idle gaps.
    seg = {};
    for (int c = 0; c < 60; c++) begin
      case ($urandom_range(0, 9))
        0: add_line("");
        1: begin add_str("set "); add_key($urandom_range(1, 6)); add_line(""); end
        2: begin
          repeat ($urandom_range(1, 5)) seg.push_back(8'($urandom));
          seg.push_back(LF);
        end
        default: begin
          add_str("get ");
          nk = $urandom_range(1, 3);
          for (int j = 0; j < nk; j++) begin
            if (j > 0) repeat ($urandom_range(1, 2)) seg.push_back(SP);
            add_key(($urandom_range(1, 10) < 10) ? $urandom_range(1, MAX_KEY)
                                                 : $urandom_range(MAX_KEY + 1, MAX_KEY + 3));
          end
          if ($urandom_range(0, 7) == 0) seg.push_back(SP);
          if ($urandom_range(0, 9) == 0) seg.push_back(8'($urandom));
          add_line("");
        end
      endcase
    end
    do_reset(); run_seg(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_key_parser.md
# mc_key_parser

Memcache ASCII front end that sits directly upstream of the lookup3 hash pipeline. It consumes the request byte stream from the connection receive path and parses `get <key>[ <key>...]\r\n` commands. For each key it emits the key packed into three 32-bit words, plus its byte length, in the form the hash pipeline samples every cycle. Malformed commands and over-long keys are flagged and discarded up to the next `\n`.

## Interface
Parameters:
- MAX_KEY, 12: maximum key bytes accepted, legal range 1..12; longer keys are errors.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- in_data  in  8  request byte.
- in_valid  in  1  in_data valid this cycle. No backpressure: every valid byte is consumed.
- k0  out  32  key bytes 0..3, first byte in [31:24].
- k1  out  32  key bytes 4..7, same packing.
- k2  out  32  key bytes 8..11, same packing.
- key_length  out  8  key byte count, 1..MAX_KEY.
- key_valid  out  1  one-cycle pulse: k0..k2 and key_length hold a new key.
- cmd_err  out  1  one-cycle pulse: protocol error detected, command discarded.

## Operation
- Commands are case-sensitive lowercase. A key byte is any of 0x21..0x7E.
- FSM states: IDLE, G, E, T, KEY, LF, DROP. State changes only on cycles where in_valid=1. When in_valid=0, all state holds.
- IDLE:
  - `g` goes to G.
  - `\r` or `\n` stays in IDLE (blank line, no error).
  - Any other byte: cmd_err, go to DROP.
- G / E / T expect `e` / `t` / space in turn. On a mismatch: cmd_err, go to DROP.
- T plus space clears the key buffer and count, clears the got_key flag, and enters KEY.
- KEY, key byte:
  - count < MAX_KEY: store the byte at index count and increment count.
  - Otherwise: cmd_err, go to DROP.
- KEY, space:
  - count > 0: emit the key, clear the buffer and count, set got_key, stay in KEY.
  - count = 0 (repeated space): ignored.
- KEY, `\r`:
  - count > 0: emit the key and go to LF.
  - count = 0 and got_key=1: go to LF with no emit.
  - count = 0 and got_key=0: cmd_err, go to DROP.
- KEY, any other byte (control character, 0x7F, 0x80..0xFF, bare `\n`): cmd_err, go to DROP. A bare `\n` goes to DROP and then waits for the next `\n`.
- LF:
  - `\n` goes to IDLE.
  - Anything else: cmd_err, go to DROP.
- DROP: `\n` goes to IDLE; any other byte stays in DROP with no further cmd_err.
- Packing: byte i occupies word i/4, bits [31-8*(i%4) : 24-8*(i%4)]. Unwritten bytes are 0.
- Emit registers k0..k2 and key_length from the buffer, and pulses key_valid. Outputs then hold until the next emit.
- Keys already emitted from a command that later errors are not retracted.

## Timing
- Reset values:
  - state IDLE.
  - k0, k1, k2 = 0; key_length = 0.
  - key_valid = 0; cmd_err = 0.
  - Buffer, count and got_key cleared.
- RST mid-command abandons the partial key and produces no emit.
- Latency:
  - key_valid rises on the cycle after the terminating byte (space or `\r`) is accepted.
  - cmd_err rises on the cycle after the offending byte is accepted.
- key_valid and cmd_err are never both high in the same cycle.
- Back-to-back emits are one valid byte apart at minimum: `get a b\r\n` with in_valid held high gives pulses two cycles apart.
- A byte arriving in the same cycle as an emit is processed normally. The emit registers are separate from the key buffer.

## Configuration
- MC_KEY_MULTI_EN defined: multi-key get supported. A space terminates a key, as described in Operation.
- MC_KEY_MULTI_EN undefined: only `\r` terminates a key.
  - Space in KEY with count > 0: cmd_err, go to DROP, no emit.
  - Space with count = 0: ignored.
  - The got_key path is unused, so `get \r` is an error.

## Test plan
- `get abcd\r\n`, in_valid continuous: one key_valid pulse with k0=0x61626364, k1=0, k2=0, key_length=4; cmd_err never asserted.
- `get abcdefghijkl\r\n`: k0=0x61626364, k1=0x65666768, k2=0x696A6B6C, key_length=12.
- `get abcdefghijklm\r\n` then `get x\r\n`:
  - cmd_err one cycle after `m`; no key_valid for the first command.
  - Then k0=0x78000000, k1=k2=0, key_length=1.
- MC_KEY_MULTI_EN defined, `get ab cd\r\n`:
  - Pulse 1: k0=0x61620000, length 2.
  - Pulse 2: k0=0x63640000, length 2.
- MC_KEY_MULTI_EN undefined, same input: cmd_err after the space, no key_valid.
- `set x\r\n` then `get q\r\n`:
  - cmd_err after `s`, then silence through `\n`.
  - Then k0=0x71000000, length 1.
- `get ab` followed by RST for one cycle, then `cd\r\n get e\r\n`:
  - All outputs return to reset values after RST.
  - `c` causes cmd_err.
  - Then one key_valid with k0=0x65000000, length 1.
- in_valid toggled every other cycle during `get abcd\r\n`: same result as the first scenario; no emit is triggered while in_valid is low.
